// File: rtl/lsu_store_queue_pkg.sv
// Shared defaults and the entry record for the LSU store queue.
package lsu_store_queue_pkg;
  localparam int SQ_DEPTH = 4;
  localparam int SQ_AW    = 16;
  localparam int SQ_DW    = 16;

  typedef struct packed {
    logic [SQ_AW-1:0] addr;
    logic [SQ_DW-1:0] data;
  } sq_entry_t;
endpackage

// File: rtl/lsu_store_queue_if.sv
// Store-queue bus bundle: RMW writeback, scheduler store, load probe, memory write port.
interface lsu_store_queue_if #(
  parameter int AW = lsu_store_queue_pkg::SQ_AW,
  parameter int DW = lsu_store_queue_pkg::SQ_DW
);
  logic          rmw_data_rdy;
  logic [AW-1:0] rmw_addr;
  logic [DW-1:0] rmw_data;
  logic          rmw_hold;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_fwd_data;
  logic          mem_wr_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_out;
  logic          mem_wr_ack;

  modport slave (
    input  rmw_data_rdy, rmw_addr, rmw_data, st_valid, st_addr, st_data, ld_addr, mem_wr_ack,
    output rmw_hold, st_ready, ld_hit, ld_fwd_data, mem_wr_req, mem_addr, mem_data_out
  );
  modport master (
    output rmw_data_rdy, rmw_addr, rmw_data, st_valid, st_addr, st_data, ld_addr, mem_wr_ack,
    input  rmw_hold, st_ready, ld_hit, ld_fwd_data, mem_wr_req, mem_addr, mem_data_out
  );
endinterface

// File: rtl/lsu_store_queue_sq_fwd_match.sv
// Load-forwarding match: scans valid entries oldest to youngest, last match wins.
module sq_fwd_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic [AW-1:0]             ld_addr,
  input  logic [DEPTH-1:0][AW-1:0]  addrs,
  input  logic [DEPTH-1:0][DW-1:0]  datas,
  input  logic [PW-1:0]             head,
  input  logic [CW-1:0]             count,
  output logic                      hit,
  output logic [DW-1:0]             data
);
  logic [DEPTH-1:0] match;
  logic [PW-1:0]    idx;

  for (genvar g = 0; g < DEPTH; g++) begin : g_lane
    assign match[g] = addrs[g] == ld_addr;
  end

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count && match[idx]) begin
        hit  = 1'b1;
        data = datas[idx];
      end
    end
  end
endmodule

// File: rtl/lsu_store_queue.sv
// Circular store queue: RMW-priority enqueue, in-order drain to memory, youngest-match load forwarding.
module lsu_store_queue
  import lsu_store_queue_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH,
  parameter int AW    = SQ_AW,
  parameter int DW    = SQ_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  lsu_store_queue_if.slave sq,
  output logic            sq_empty,
  output logic            sq_full,
  output logic [CW-1:0]   sq_count
);
  logic [PW-1:0]            head_q, tail_q;
  logic [CW-1:0]            count_q;
  logic [DEPTH-1:0][AW-1:0] addr_mem;
  logic [DEPTH-1:0][DW-1:0] data_mem;
  logic                     enq, deq;
  logic [AW-1:0]            enq_addr;
  logic [DW-1:0]            enq_data;

  assign sq_full  = count_q == CW'(DEPTH);
  assign sq_empty = count_q == '0;
  assign sq_count = count_q;

  // Full refuses enqueue even when the head drains this same cycle.
  assign enq      = ~sq_full & (sq.rmw_data_rdy | sq.st_valid);
  assign deq      = sq.mem_wr_ack & ~sq_empty;
  assign enq_addr = sq.rmw_data_rdy ? sq.rmw_addr : sq.st_addr;
  assign enq_data = sq.rmw_data_rdy ? sq.rmw_data : sq.st_data;

  assign sq.rmw_hold     = sq.rmw_data_rdy & sq_full;
  assign sq.st_ready     = ~sq_full & ~sq.rmw_data_rdy;
  assign sq.mem_wr_req   = ~sq_empty;
  assign sq.mem_addr     = sq_empty ? '0 : addr_mem[head_q];
  assign sq.mem_data_out = sq_empty ? '0 : data_mem[head_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + PW'(1);
      if (deq) head_q <= head_q + PW'(1);
      count_q <= count_q + CW'(enq) - CW'(deq);
    end
  end

  // Payload storage is never reset; every read is qualified by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail_q] <= enq_addr;
      data_mem[tail_q] <= enq_data;
    end
  end

  sq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd (
    .ld_addr (sq.ld_addr),
    .addrs   (addr_mem),
    .datas   (data_mem),
    .head    (head_q),
    .count   (count_q),
    .hit     (sq.ld_hit),
    .data    (sq.ld_fwd_data)
  );
endmodule
